// File: rtl/warp_barrier_ctrl.sv
// Warp barrier controller: tracks arrivals per barrier id, stalls warps until the
// expected count has arrived, then hands one release mask to the warp scheduler.
module warp_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_BITS-1:0]   req_wid,
  input  logic [NB_BITS-1:0]   req_id,
  input  logic [NW_BITS-1:0]   req_size_m1,
  output logic [NUM_WARPS-1:0] stalled_mask,
  output logic                 release_valid,
  input  logic                 release_ready,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic [NB_BITS-1:0]   release_id,
  output logic                 err_dup,
  output logic                 err_size
);

  typedef struct packed {
    logic                 valid;
    logic [NW_BITS-1:0]   size_m1;
    logic [NUM_WARPS-1:0] mask;
    logic [NW_BITS-1:0]   count;  // arrivals minus one
  } entry_t;

  entry_t                 r_table [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   r_stalled;
  logic                   r_rel_valid;
  logic [NUM_WARPS-1:0]   r_rel_mask;
  logic [NB_BITS-1:0]     r_rel_id;
  logic                   r_err_dup;
  logic                   r_err_size;

  logic                   w_accept;
  entry_t                 w_ent;
  entry_t                 w_ent_next;
  logic [NUM_WARPS-1:0]   w_onehot;
  logic [NW_BITS-1:0]     w_cnt_inc;
  logic                   w_dup;
  logic                   w_size_err;
  logic                   w_fire;
  logic [NUM_WARPS-1:0]   w_fire_mask;
  logic [NUM_WARPS-1:0]   w_stall_set;
  logic [NUM_WARPS-1:0]   w_stall_clr;

  // A single release register: new arrivals wait until the scheduler takes it.
  assign req_ready = !r_rel_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_ent     = r_table[req_id];
  assign w_onehot  = {{(NUM_WARPS-1){1'b0}}, 1'b1} << req_wid;
  assign w_cnt_inc = w_ent.count + NW_BITS'(1);
  assign w_dup     = w_ent.valid && ((w_ent.mask & w_onehot) != '0);
  // The latched size stays authoritative; a mismatch is only flagged.
  assign w_size_err = w_ent.valid && !w_dup && (req_size_m1 != w_ent.size_m1);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_ent_next  = w_ent;
    w_fire      = 1'b0;
    w_fire_mask = '0;
    w_stall_set = '0;
    w_stall_clr = '0;
    if (w_accept) begin
      if (!w_ent.valid) begin
        if (req_size_m1 == '0) begin
          w_fire      = 1'b1;
          w_fire_mask = w_onehot;
        end else begin
          w_ent_next.valid   = 1'b1;
          w_ent_next.size_m1 = req_size_m1;
          w_ent_next.mask    = w_onehot;
          w_ent_next.count   = '0;
          w_stall_set        = w_onehot;
        end
      end else if (w_dup) begin
        w_ent_next = w_ent;
      end else if (w_cnt_inc == w_ent.size_m1) begin
        w_fire      = 1'b1;
        w_fire_mask = w_ent.mask | w_onehot;
        w_ent_next  = '0;
        w_stall_clr = w_ent.mask;
      end else begin
        w_ent_next.mask  = w_ent.mask | w_onehot;
        w_ent_next.count = w_cnt_inc;
        w_stall_set      = w_onehot;
      end
    end
  end

  // NOTE: the barrier table is reset along with the control state because a
  // mid-operation reset must drop every half-collected barrier, and it is tiny.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BARRIERS; i++) r_table[i] <= '0;
    end else if (w_accept) begin
      r_table[req_id] <= w_ent_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stalled   <= '0;
      r_rel_valid <= 1'b0;
      r_rel_mask  <= '0;
      r_rel_id    <= '0;
      r_err_dup   <= 1'b0;
      r_err_size  <= 1'b0;
    end else begin
      r_stalled <= (r_stalled & ~w_stall_clr) | w_stall_set;
      if (w_fire) begin
        r_rel_valid <= 1'b1;
        r_rel_mask  <= w_fire_mask;
        r_rel_id    <= req_id;
      end else if (r_rel_valid && release_ready) begin
        r_rel_valid <= 1'b0;
      end
      if (w_accept && w_dup)      r_err_dup  <= 1'b1;
      if (w_accept && w_size_err) r_err_size <= 1'b1;
    end
  end

  assign stalled_mask  = r_stalled;
  assign release_valid = r_rel_valid;
  assign release_mask  = r_rel_mask;
  assign release_id    = r_rel_id;
  assign err_dup       = r_err_dup;
  assign err_size      = r_err_size;

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Bench for warp_barrier_ctrl: per-cycle vector table plus a release scoreboard,
// with a hand-written asynchronous reset sequence in the middle.
module tb_warp_barrier_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [1:0] req_id;
  logic [1:0] req_size_m1;
  logic [3:0] stalled_mask;
  logic       release_valid;
  logic       release_ready;
  logic [3:0] release_mask;
  logic [1:0] release_id;
  logic       err_dup;
  logic       err_size;

  int checks = 0;
  int errors = 0;

  warp_barrier_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wid(req_wid), .req_id(req_id), .req_size_m1(req_size_m1),
    .stalled_mask(stalled_mask),
    .release_valid(release_valid), .release_ready(release_ready),
    .release_mask(release_mask), .release_id(release_id),
    .err_dup(err_dup), .err_size(err_size)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] wid, id, sz;
    logic       rr;
    logic [3:0] e_stall;
    logic       e_rv;
    logic [3:0] e_rmask;
    logic [1:0] e_rid;
    logic       e_dup, e_size, e_rdy;
    logic       push;
    logic [3:0] pmask;
    logic [1:0] pid;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];  // {release_mask, release_id}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sz,
    input logic rr, input logic [3:0] e_stall, input logic e_rv, input logic [3:0] e_rmask,
    input logic [1:0] e_rid, input logic e_dup, input logic e_size, input logic e_rdy,
    input logic push, input logic [3:0] pmask, input logic [1:0] pid);
    vec_t t;
    t.v = v; t.wid = wid; t.id = id; t.sz = sz; t.rr = rr;
    t.e_stall = e_stall; t.e_rv = e_rv; t.e_rmask = e_rmask; t.e_rid = e_rid;
    t.e_dup = e_dup; t.e_size = e_size; t.e_rdy = e_rdy;
    t.push = push; t.pmask = pmask; t.pid = pid;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [5:0] got;
    logic [5:0] exp;
    @(negedge clk);
    req_valid     = t.v;
    req_wid       = t.wid;
    req_id        = t.id;
    req_size_m1   = t.sz;
    release_ready = t.rr;
    if (t.push) exp_q.push_back({t.pmask, t.pid});
    #1;
    if (release_valid && release_ready) begin
      got = {release_mask, release_id};
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d unexpected_release", idx), got, 6'h3f);
        checks++;
        errors++;
        $display("FAIL v%0d release_scoreboard: got %0h expected none", idx, got);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("v%0d release_scoreboard", idx), got, exp);
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d stalled_mask", idx), stalled_mask, t.e_stall);
    check($sformatf("v%0d release_valid", idx), release_valid, t.e_rv);
    check($sformatf("v%0d release_mask", idx), release_mask, t.e_rmask);
    check($sformatf("v%0d release_id", idx), release_id, t.e_rid);
    check($sformatf("v%0d err_dup", idx), err_dup, t.e_dup);
    check($sformatf("v%0d err_size", idx), err_size, t.e_size);
    check($sformatf("v%0d req_ready", idx), req_ready, t.e_rdy);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // v  wid id sz rr  stall rv rmask rid dup size rdy push pmask pid
    // Four warps at barrier 2
    vecs.push_back(mk(1, 0, 2, 3, 1, 4'b0001, 0, 4'b0000, 0, 0, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 2, 3, 1, 4'b0011, 0, 4'b0000, 0, 0, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 2, 2, 3, 1, 4'b0111, 0, 4'b0000, 0, 0, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 3, 2, 3, 1, 4'b0000, 1, 4'b1111, 2, 0, 0, 0, 1, 4'b1111, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 4'b1111, 2, 0, 0, 1, 0, 4'b0000, 0));
    // Single-warp barrier, then 3 cycles of backpressure with a blocked request
    vecs.push_back(mk(1, 1, 0, 0, 1, 4'b0000, 1, 4'b0010, 0, 0, 0, 0, 1, 4'b0010, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0010, 0, 0, 0, 1, 0, 4'b0000, 0));
    // Duplicate arrival at barrier 1
    vecs.push_back(mk(1, 2, 1, 2, 1, 4'b0100, 0, 4'b0010, 0, 0, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 2, 1, 2, 1, 4'b0100, 0, 4'b0010, 0, 1, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 1, 2, 1, 4'b0101, 0, 4'b0010, 0, 1, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 3, 1, 2, 1, 4'b0000, 1, 4'b1101, 1, 1, 0, 0, 1, 4'b1101, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 4'b1101, 1, 1, 0, 1, 0, 4'b0000, 0));
    // Size mismatch with barrier 3 interleaved
    vecs.push_back(mk(1, 0, 0, 1, 1, 4'b0001, 0, 4'b1101, 1, 1, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 4'b0011, 0, 4'b1101, 1, 1, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 2, 0, 3, 1, 4'b0010, 1, 4'b0101, 0, 1, 1, 0, 1, 4'b0101, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0010, 0, 4'b0101, 0, 1, 1, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 4'b0011, 0, 4'b0101, 0, 1, 1, 1, 0, 4'b0000, 0));
    // After mid-run reset: barrier 3 must start empty
    vecs.push_back(mk(1, 3, 3, 1, 1, 4'b1000, 0, 4'b0000, 0, 0, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 4'b0000, 1, 4'b1010, 3, 0, 0, 0, 1, 4'b1010, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 4'b1010, 3, 0, 0, 1, 0, 4'b0000, 0));

    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_wid       = '0;
    req_id        = '0;
    req_size_m1   = '0;
    release_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset stalled_mask", stalled_mask, 4'b0000);
    check("reset release_valid", release_valid, 1'b0);
    check("reset release_mask", release_mask, 4'b0000);
    check("reset release_id", release_id, 2'd0);
    check("reset errors", {err_dup, err_size}, 2'b00);
    check("reset req_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(vecs[i], i);

    // Asynchronous reset between edges with stalled_mask = 0011
    @(posedge clk);
    #3;
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("async stalled_mask", stalled_mask, 4'b0000);
    check("async release_valid", release_valid, 1'b0);
    check("async err_dup", err_dup, 1'b0);
    check("async err_size", err_size, 1'b0);
    check("async req_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 20; i < vecs.size(); i++) apply(vecs[i], i);

    check("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_barrier_ctrl.md
Name: warp_barrier_ctrl

Overview:
- Receiving end of the core's warp-barrier request (valid, barrier id, size_m1) sent by the GPU unit when a warp executes a BAR instruction.
- Keeps a table of NUM_BARRIERS entries, one per barrier id, recording which warps have arrived and the expected warp count.
- Stalls each arriving warp until all warps have arrived, then sends one release mask to the warp scheduler.
- Sits between the GPU functional unit and the warp scheduler.

Parameters:
- NUM_WARPS, 4, warps per core; must be ≥2.
- NUM_BARRIERS, 4, barrier table entries.
- NW_BITS, clog2(NUM_WARPS), warp-id width.
- NB_BITS, clog2(NUM_BARRIERS), barrier-id width.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  barrier request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wid  in  NW_BITS  id of the arriving warp.
- req_id  in  NB_BITS  barrier id.
- req_size_m1  in  NW_BITS  number of participating warps minus 1.
- stalled_mask  out  NUM_WARPS  warps currently held at any barrier (registered).
- release_valid  out  1  release pending.
- release_ready  in  1  scheduler accepts the release.
- release_mask  out  NUM_WARPS  warps to wake.
- release_id  out  NB_BITS  barrier being released.
- err_dup  out  1  sticky: a warp arrived twice at the same open barrier.
- err_size  out  1  sticky: req_size_m1 did not match the size latched for an open barrier.

Behaviour:
- Reset (asynchronous, reset_n=0): all entries are invalid with mask=0 and count=0. Outputs: stalled_mask=0, release_valid=0, release_mask=0, release_id=0, err_dup=0, err_size=0, req_ready=1.
- Entry state: valid, size_m1 (latched by the first arrival), mask[NUM_WARPS], count[NW_BITS] (arrivals minus 1).
- req_ready = !release_valid. There is one release register, so requests are blocked while a release is pending.
- Accepted request, entry invalid, req_size_m1 != 0:
  - entry becomes valid; size_m1 = req_size_m1; mask = onehot(req_wid); count = 0.
  - stalled_mask bit req_wid is set on the next edge.
- Accepted request, entry invalid, req_size_m1 == 0 (single-warp barrier):
  - the entry is not allocated.
  - next cycle: release_valid=1, release_mask=onehot(req_wid), release_id=req_id.
  - the stalled bit is never set.
- Accepted request, entry valid, bit req_wid already set in mask: the request is ignored and err_dup is set. The entry is unchanged.
- Accepted request, entry valid, req_size_m1 != latched size_m1: err_size is set. The latched size is kept and the arrival is still processed.
- Accepted request, entry valid, count+1 < size_m1: the mask bit is set, count increments, and the stalled bit is set.
- Accepted request, entry valid, count+1 == size_m1 (completing arrival), on the next edge:
  - release_valid=1; release_mask = mask | onehot(req_wid); release_id = req_id.
  - the entry is cleared to invalid.
  - stalled_mask clears the bits in mask.
- Release handshake:
  - release_valid, release_mask and release_id hold stable until release_valid && release_ready.
  - On that edge release_valid returns to 0. release_mask and release_id keep their last value.
- Release latency: 1 cycle from the completing request's accept edge to release_valid=1.
- Independent barriers: other table entries may hold partial state while a release is pending.
- Table capacity: the table never overflows because each barrier id maps to a fixed entry.
- Count width: count never exceeds NUM_WARPS-1, so NW_BITS is sufficient.
- err_dup and err_size clear only on reset.
- Reset mid-operation: all pending barriers and any pending release are dropped. Stalled warps are recovered by the scheduler's own reset.

Test Plan:
- Release after four warps: warps 0,1,2,3 arrive at barrier 2 with size_m1=3, one per cycle → stalled_mask goes 0001, 0011, 0111; the cycle after warp 3 is accepted, release_valid=1, release_mask=1111, release_id=2, stalled_mask=0000.
- Single-warp barrier: warp 1, barrier 0, size_m1=0 → next cycle release_valid=1, release_mask=0010; stalled_mask stays 0000.
- Backpressure: hold release_ready=0 for 3 cycles with a release pending → req_ready=0 and release_mask stable for 3 cycles; a new req_valid is not accepted; after release_ready=1, req_ready=1 again.
- Duplicate arrival: warp 2 arrives at barrier 1 twice with size_m1=2 → err_dup=1, count unchanged, stalled_mask=0100; arrivals from warps 0 and 3 then release mask 1101.
- Size mismatch and interleaving: barrier 0 (size_m1=1) receives warp 0; barrier 3 (size_m1=1) receives warp 1; barrier 0 receives warp 2 with size_m1=3 → err_size=1, barrier 0 releases 0101, barrier 3 stays pending with stalled_mask=0010.
- Asynchronous reset: with stalled_mask=0011, assert reset_n=0 between clock edges → stalled_mask, release_valid and errors go to 0 immediately; after deassertion, a new 2-warp barrier behaves normally.
